mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline: consumes the XM latch outputs, performs loads and stores against a handshaked data memory, and drives the inputs and write enable of the MW latch. Multi-cycle memory ops stall everything upstream, and bubbles go into writeback while they wait. A timeout squashes accesses that never complete and records a sticky fault.

---
 rtl/mem_stage_pkg.sv | 20 ++
 rtl/mem_stage_if.sv | 14 +
 rtl/mem_timeout_counter.sv | 25 ++
 rtl/register.sv | 17 +
 rtl/mem_stage.sv | 130 +++++++++++++
 tb/tb_mem_stage.sv | 262 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants, FSM state type and control-word helpers for the memory-access stage.
package mem_stage_pkg;

    localparam int CTRL_W      = 14;
    localparam int CTRL_MEM_RD = 3;
    localparam int CTRL_MEM_WR = 4;

    localparam logic [CTRL_W-1:0] BUBBLE = 14'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic logic ctrl_is_mem(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEM_RD] | ctrl[CTRL_MEM_WR];
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Handshaked data-memory port: the stage is the master, the memory the slave.
interface mem_stage_if #(
    parameter int ADDR_W = 12
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;

    modport master (output req, we, addr, wdata, input  ack, rdata);
    modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_timeout_counter.sv
// Counts ACCESS cycles; expired flags the last cycle an access may still be acked.
module mem_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Saturates at LAST so a stuck count_en cannot wrap back into range.
    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (count_en && count != LAST)
            count <= count + CW'(1);
    end

    assign expired = (count == LAST);
endmodule

// File: rtl/register.sv
// Generic pipeline register with load enable and synchronous active-high reset.
module register #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clock) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU ops straight to MW, runs loads/stores over the
// handshaked data port while stalling upstream, and squashes accesses that time out.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              xm_valid,
    input  logic [31:0]       xm_ALU_result,
    input  logic [31:0]       xm_store_data,
    input  logic [4:0]        xm_rd,
    input  logic [CTRL_W-1:0] xm_ctrl_signals,
    input  logic [31:0]       xm_PC_next,
    output logic              stall,
    mem_stage_if.master       dmem,
    output logic [31:0]       mw_ALU_result,
    output logic [31:0]       mw_data_read,
    output logic [31:0]       mw_PC_next,
    output logic [4:0]        mw_rd,
    output logic [CTRL_W-1:0] mw_ctrl_signals,
    output logic              mw_wren,
    output logic              mem_fault
);
    state_t      state;
    logic        req_q, fault_q, squashed_q;
    logic        is_mem_op, capture, ack_take, expired, tmo_clear, tmo_count;
    logic [31:0] addr_hold, wdata_hold, pc_hold, data_hold, data_next;
    logic [19:0] meta_hold;
    logic [4:0]  rd_hold;
    logic [CTRL_W-1:0] ctrl_hold;
    logic        we_hold;

    assign is_mem_op = xm_valid && ctrl_is_mem(xm_ctrl_signals);
    assign capture   = (state == IDLE) && is_mem_op;
    assign ack_take  = (state == ACCESS) && dmem.ack;
    assign tmo_clear = (state != ACCESS);
    assign tmo_count = (state == ACCESS);

    // The write bit alone decides direction, so RD+WR together behaves as a store.
    register #(.WIDTH(32)) u_addr_hold  (.clock, .reset, .en(capture), .d(xm_ALU_result), .q(addr_hold));
    register #(.WIDTH(32)) u_wdata_hold (.clock, .reset, .en(capture), .d(xm_store_data), .q(wdata_hold));
    register #(.WIDTH(32)) u_pc_hold    (.clock, .reset, .en(capture), .d(xm_PC_next),    .q(pc_hold));
    register #(.WIDTH(20)) u_meta_hold  (.clock, .reset, .en(capture),
                                         .d({xm_ctrl_signals[CTRL_MEM_WR], xm_ctrl_signals, xm_rd}),
                                         .q(meta_hold));
    assign {we_hold, ctrl_hold, rd_hold} = meta_hold;

    assign data_next = we_hold ? 32'h0 : dmem.rdata;
    register #(.WIDTH(32)) u_data_hold  (.clock, .reset, .en(ack_take), .d(data_next), .q(data_hold));

    mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock, .reset, .clear(tmo_clear), .count_en(tmo_count), .expired
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            fault_q    <= 1'b0;
            squashed_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (is_mem_op) begin
                        state      <= ACCESS;
                        req_q      <= 1'b1;
                        squashed_q <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (dmem.ack) begin
                        state <= RESP;
                        req_q <= 1'b0;
                    end else if (expired) begin
                        state      <= RESP;
                        req_q      <= 1'b0;
                        fault_q    <= 1'b1;
                        squashed_q <= 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign dmem.req   = req_q & ~reset;
    assign dmem.we    = req_q & we_hold & ~reset;
    assign dmem.addr  = addr_hold[ADDR_W-1:0];
    assign dmem.wdata = wdata_hold;
    assign mem_fault  = fault_q & ~reset;

    // Bubbles (all-zero MW inputs) are written while a memory op is in flight.
    always_comb begin
        stall           = 1'b0;
        mw_wren         = 1'b0;
        mw_ALU_result   = '0;
        mw_data_read    = '0;
        mw_PC_next      = '0;
        mw_rd           = '0;
        mw_ctrl_signals = BUBBLE;
        if (!reset) begin
            mw_wren = 1'b1;
            unique case (state)
                IDLE: begin
                    if (is_mem_op) begin
                        stall = 1'b1;
                    end else begin
                        mw_ALU_result   = xm_ALU_result;
                        mw_PC_next      = xm_PC_next;
                        mw_rd           = xm_rd;
                        mw_ctrl_signals = xm_valid ? xm_ctrl_signals : BUBBLE;
                    end
                end
                ACCESS: stall = 1'b1;
                RESP: begin
                    mw_ALU_result   = addr_hold;
                    mw_PC_next      = pc_hold;
                    mw_rd           = rd_hold;
                    mw_ctrl_signals = squashed_q ? BUBBLE : ctrl_hold;
                    mw_data_read    = squashed_q ? 32'h0 : data_hold;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table for pass-through, directed
// memory-op sequences, and randomized ops against a transaction-level model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        xm_valid;
    logic [31:0] xm_ALU_result, xm_store_data, xm_PC_next;
    logic [4:0]  xm_rd;
    logic [13:0] xm_ctrl_signals;
    logic        stall, mw_wren, mem_fault;
    logic [31:0] mw_ALU_result, mw_data_read, mw_PC_next;
    logic [4:0]  mw_rd;
    logic [13:0] mw_ctrl_signals;

    int checks = 0;
    int errors = 0;
    bit exp_fault = 0;

    always #5 clock = ~clock;

    mem_stage_if #(.ADDR_W(ADDR_W)) dmem_bus ();

    mem_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock           (clock),
        .reset           (reset),
        .xm_valid        (xm_valid),
        .xm_ALU_result   (xm_ALU_result),
        .xm_store_data   (xm_store_data),
        .xm_rd           (xm_rd),
        .xm_ctrl_signals (xm_ctrl_signals),
        .xm_PC_next      (xm_PC_next),
        .stall           (stall),
        .dmem            (dmem_bus),
        .mw_ALU_result   (mw_ALU_result),
        .mw_data_read    (mw_data_read),
        .mw_PC_next      (mw_PC_next),
        .mw_rd           (mw_rd),
        .mw_ctrl_signals (mw_ctrl_signals),
        .mw_wren         (mw_wren),
        .mem_fault       (mem_fault)
    );

    typedef struct {
        logic        v;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [13:0] ctrl;
        logic [31:0] pc;
        logic [13:0] exp_ctrl;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        dmem_bus.ack   = 1'b0;
        dmem_bus.rdata = $urandom;
    endtask

    // Non-memory instruction: everything visible in the same cycle, no stall.
    task automatic run_alu(input string tag, input logic v, input logic [31:0] alu,
                           input logic [4:0] rd, input logic [13:0] ctrl,
                           input logic [31:0] pc, input logic [13:0] exp_ctrl);
        xm_valid = v; xm_ALU_result = alu; xm_rd = rd; xm_ctrl_signals = ctrl;
        xm_PC_next = pc; xm_store_data = $urandom;
        @(negedge clock);
        chk({tag, " alu"},   mw_ALU_result, alu);
        chk({tag, " rd"},    mw_rd, rd);
        chk({tag, " pc"},    mw_PC_next, pc);
        chk({tag, " ctrl"},  mw_ctrl_signals, exp_ctrl);
        chk({tag, " data"},  mw_data_read, 32'h0);
        chk({tag, " stall"}, stall, 1'b0);
        chk({tag, " wren"},  mw_wren, 1'b1);
        chk({tag, " req"},   dmem_bus.req, 1'b0);
        tick();
    endtask

    // Memory op; k = ACCESS cycle in which the memory acks (0 = never).
    task automatic run_mem(input string tag, input bit st, input bit ld,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [4:0] rd, input logic [13:0] ctrl_in,
                           input logic [31:0] pc, input logic [31:0] rdata, input int k);
        logic [13:0] ctrl;
        bit squash, done;
        int stalls, reqs, bad_bus, bad_bubble;
        ctrl = ctrl_in;
        ctrl[CTRL_MEM_RD] = ld;
        ctrl[CTRL_MEM_WR] = st;
        squash = (k < 1) || (k > TIMEOUT);
        if (squash) exp_fault = 1;
        done = 0; stalls = 0; reqs = 0; bad_bus = 0; bad_bubble = 0;
        xm_valid = 1'b1; xm_ALU_result = addr; xm_store_data = wd;
        xm_rd = rd; xm_ctrl_signals = ctrl; xm_PC_next = pc;
        for (int c = 0; c < TIMEOUT + 8 && !done; c++) begin
            @(negedge clock);
            if (stall) begin
                stalls++;
                if (mw_ctrl_signals !== 14'h0 || mw_wren !== 1'b1 || mw_data_read !== 32'h0 ||
                    mw_rd !== 5'h0 || mw_ALU_result !== 32'h0)
                    bad_bubble++;
                if (dmem_bus.req) begin
                    reqs++;
                    if (dmem_bus.we !== st || dmem_bus.addr !== addr[ADDR_W-1:0] ||
                        dmem_bus.wdata !== wd)
                        bad_bus++;
                    if (reqs == k) begin
                        dmem_bus.ack   = 1'b1;
                        dmem_bus.rdata = rdata;
                    end
                end
            end else begin
                done = 1;
                chk({tag, " resp alu"},  mw_ALU_result, addr);
                chk({tag, " resp rd"},   mw_rd, rd);
                chk({tag, " resp pc"},   mw_PC_next, pc);
                chk({tag, " resp ctrl"}, mw_ctrl_signals, squash ? 14'h0 : ctrl);
                chk({tag, " resp data"}, mw_data_read, (squash || st) ? 32'h0 : rdata);
                chk({tag, " resp wren"}, mw_wren, 1'b1);
                chk({tag, " resp req"},  dmem_bus.req, 1'b0);
                chk({tag, " fault"},     mem_fault, exp_fault);
            end
            tick();
        end
        chk({tag, " completed"}, done, 1'b1);
        chk({tag, " stall cycles"}, stalls, squash ? TIMEOUT + 1 : k + 1);
        chk({tag, " req cycles"},   reqs,   squash ? TIMEOUT : k);
        chk({tag, " bus held"},     bad_bus, 0);
        chk({tag, " bubbles"},      bad_bubble, 0);
    endtask

    initial begin
        vec_t vecs[4];
        logic [5:0] pattern;

        dmem_bus.ack = 1'b0; dmem_bus.rdata = 32'h0;
        reset = 1'b1;
        xm_valid = 1'b1; xm_ALU_result = 32'h10; xm_store_data = 32'h55;
        xm_rd = 5'd3; xm_ctrl_signals = 14'h0008; xm_PC_next = 32'h40;

        // Reset with a pending load on XM: everything must stay quiet.
        @(negedge clock);
        chk("rst wren",  mw_wren, 1'b0);
        chk("rst stall", stall, 1'b0);
        chk("rst req",   dmem_bus.req, 1'b0);
        chk("rst fault", mem_fault, 1'b0);
        chk("rst ctrl",  mw_ctrl_signals, 14'h0);
        tick();
        reset = 1'b0; xm_valid = 1'b0;
        @(negedge clock);
        chk("post-rst req",   dmem_bus.req, 1'b0);
        chk("post-rst fault", mem_fault, 1'b0);
        tick();

        vecs[0] = '{1'b1, 32'h0000_002A, 5'd5,  14'h0001, 32'h0000_0101, 14'h0001};
        vecs[1] = '{1'b0, 32'h0000_1234, 5'd7,  14'h0001, 32'h0000_0200, 14'h0000};
        vecs[2] = '{1'b1, 32'hFFFF_FFFF, 5'd31, 14'h3FE7, 32'hFFFF_FFFE, 14'h3FE7};
        vecs[3] = '{1'b0, 32'h0000_0010, 5'd9,  14'h0018, 32'h0000_0033, 14'h0000};
        for (int i = 0; i < 4; i++)
            run_alu($sformatf("vec%0d", i), vecs[i].v, vecs[i].alu, vecs[i].rd,
                    vecs[i].ctrl, vecs[i].pc, vecs[i].exp_ctrl);

        run_mem("load imm",   0, 1, 32'h10, 32'h0,    5'd8, 14'h0001, 32'h11, 32'hDEADBEEF, 1);
        run_mem("store k3",   1, 0, 32'h20, 32'h1234, 5'd0, 14'h0000, 32'h21, 32'hCAFEF00D, 3);
        run_mem("rdwr store", 1, 1, 32'h30, 32'hA5A5, 5'd4, 14'h0002, 32'h31, 32'h77777777, 2);
        run_mem("load tmo",   0, 1, 32'h44, 32'h0,    5'd6, 14'h0001, 32'h45, 32'h12345678, 0);

        // Late ack after the timeout must be ignored.
        xm_valid = 1'b0;
        dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'hBAD0BAD0;
        @(negedge clock);
        chk("late ack req",   dmem_bus.req, 1'b0);
        chk("late ack stall", stall, 1'b0);
        chk("late ack fault", mem_fault, 1'b1);
        chk("late ack data",  mw_data_read, 32'h0);
        tick();
        @(negedge clock);
        chk("after late ack req", dmem_bus.req, 1'b0);
        tick();

        // Two back-to-back loads, each acked in its first ACCESS cycle.
        xm_valid = 1'b1; xm_ALU_result = 32'h50; xm_rd = 5'd10;
        xm_ctrl_signals = 14'h0009; xm_PC_next = 32'h60; xm_store_data = 32'h0;
        pattern = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            pattern = {pattern[4:0], stall};
            if (dmem_bus.req) begin
                dmem_bus.ack   = 1'b1;
                dmem_bus.rdata = (c < 3) ? 32'h1111_AAAA : 32'h2222_BBBB;
            end
            if (c == 2) begin
                chk("b2b first data", mw_data_read, 32'h1111_AAAA);
                chk("b2b first rd",   mw_rd, 5'd10);
            end
            if (c == 5) begin
                chk("b2b second data", mw_data_read, 32'h2222_BBBB);
                chk("b2b second rd",   mw_rd, 5'd11);
            end
            tick();
            if (c == 2) begin
                xm_ALU_result = 32'h51; xm_rd = 5'd11; xm_PC_next = 32'h61;
            end
        end
        chk("b2b stall pattern", pattern, 6'b110110);
        xm_valid = 1'b0;

        // Reset during the second ACCESS cycle abandons the op and clears the fault.
        xm_valid = 1'b1; xm_ALU_result = 32'h70; xm_rd = 5'd12;
        xm_ctrl_signals = 14'h0008; xm_PC_next = 32'h71;
        tick();
        tick();
        reset = 1'b1;
        @(negedge clock);
        chk("rst-in-access wren", mw_wren, 1'b0);
        tick();
        reset = 1'b0; xm_valid = 1'b0; exp_fault = 0;
        @(negedge clock);
        chk("rst-in-access req",   dmem_bus.req, 1'b0);
        chk("rst-in-access stall", stall, 1'b0);
        chk("rst-in-access fault", mem_fault, 1'b0);
        tick();
        run_mem("load after rst", 0, 1, 32'h80, 32'h0, 5'd13, 14'h0001, 32'h81, 32'h0BADCAFE, 1);

        // Randomized mix checked against the transaction model.
        for (int i = 0; i < 30; i++) begin
            logic        v, st, ld;
            logic [13:0] ctrl;
            int          k;
            if ($urandom_range(0, 3) == 0) begin
                v = 1'($urandom);
                ctrl = 14'($urandom);
                if (v) begin
                    ctrl[CTRL_MEM_RD] = 1'b0;
                    ctrl[CTRL_MEM_WR] = 1'b0;
                end
                run_alu($sformatf("rnd%0d alu", i), v, $urandom, 5'($urandom), ctrl,
                        $urandom, v ? ctrl : 14'h0);
            end else begin
                st = 1'($urandom);
                ld = st ? 1'($urandom) : 1'b1;
                k  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
                run_mem($sformatf("rnd%0d mem", i), st, ld, $urandom, $urandom,
                        5'($urandom), 14'($urandom), $urandom, $urandom, k);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
